// File: rtl/jisuan_state_gen_if.sv
// Block-state stream from jisuan_state_gen toward the
// ChaCha/Salsa double-round core.
interface jisuan_state_gen_if;
  logic         out_vld;
  logic         out_rdy;
  logic [511:0] x_out_cha;
  logic [511:0] x_out_sha;

  modport master (
    output out_vld,
    output x_out_cha,
    output x_out_sha,
    input  out_rdy
  );

  modport slave (
    input  out_vld,
    input  x_out_cha,
    input  x_out_sha,
    output out_rdy
  );
endinterface

// File: rtl/jisuan_state_gen.sv
// Initial-state generator: latches key/nonce/counter and
// streams cfg_nblk ChaCha and Salsa20 input blocks.
module jisuan_state_gen #(
  parameter int          NB_W = 16,
  parameter logic [31:0] C0   = 32'h61707865,
  parameter logic [31:0] C1   = 32'h3320646e,
  parameter logic [31:0] C2   = 32'h79622d32,
  parameter logic [31:0] C3   = 32'h6b206574
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_vld,
  output logic            cfg_rdy,
  input  logic [255:0]    cfg_key,
  input  logic [95:0]     cfg_nonce,
  input  logic [63:0]     cfg_ctr,
  input  logic [NB_W-1:0] cfg_nblk,
  input  logic            abort,
  jisuan_state_gen_if.master out_if,
  output logic            busy,
  output logic            done,
  output logic            ctr_wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            done_q;
  logic            done_d;
  logic            wrap_q;
  logic [255:0]    key_q;
  logic [95:0]     nonce_q;
  logic [63:0]     ctr_q;
  logic [NB_W-1:0] rem_q;

  logic cfg_acc;
  logic hs;
  logic last;

  assign cfg_acc = cfg_vld && (state_q == IDLE);
  assign hs      = (state_q == RUN) && out_if.out_rdy;
  assign last    = (rem_q == NB_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (cfg_vld) begin
          if (cfg_nblk == '0) done_d  = 1'b1;
          else                state_d = RUN;
        end
      end
      (state_q == RUN): begin
        if (hs && last) begin
          state_d = IDLE;
          done_d  = !abort;
        end
        if (abort) state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
      rem_q   <= '0;
    end else if (cfg_acc) begin
      key_q   <= cfg_key;
      nonce_q <= cfg_nonce;
      ctr_q   <= cfg_ctr;
      rem_q   <= cfg_nblk;
    end else if (hs) begin
      ctr_q   <= ctr_q + 64'd1;
      rem_q   <= rem_q - NB_W'(1);
    end
  end

  // Only a wrap that feeds a further beat is reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else if (cfg_acc) begin
      wrap_q <= 1'b0;
    end else if (hs && ctr_q[31:0] == 32'hFFFF_FFFF
                 && rem_q > NB_W'(1)) begin
      wrap_q <= 1'b1;
    end
  end

  assign out_if.x_out_cha = {
    nonce_q, ctr_q[31:0], key_q,
    C3, C2, C1, C0
  };

  assign out_if.x_out_sha = {
    C3, key_q[255:128], C2, ctr_q,
    nonce_q[63:0], C1, key_q[127:0], C0
  };

  assign out_if.out_vld = (state_q == RUN);
  assign cfg_rdy        = (state_q == IDLE);
  assign busy           = (state_q == RUN);
  assign done           = done_q;
  assign ctr_wrap       = wrap_q;

endmodule

// File: tb/tb_jisuan_state_gen.sv
// Bench for jisuan_state_gen: queue-based block model
// plus directed vectors with literal expectations.
module tb_jisuan_state_gen;
  localparam logic [31:0] C0 = 32'h61707865;
  localparam logic [31:0] C1 = 32'h3320646e;
  localparam logic [31:0] C2 = 32'h79622d32;
  localparam logic [31:0] C3 = 32'h6b206574;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_vld = 1'b0;
  logic [255:0] cfg_key = '0;
  logic [95:0]  cfg_nonce = '0;
  logic [63:0]  cfg_ctr = '0;
  logic [15:0]  cfg_nblk = '0;
  logic         abort = 1'b0;
  logic         out_rdy = 1'b1;
  logic         cfg_rdy;
  logic         busy;
  logic         done;
  logic         ctr_wrap;

  jisuan_state_gen_if bus ();
  assign bus.out_rdy = out_rdy;

  jisuan_state_gen #(.NB_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_vld  (cfg_vld),
    .cfg_rdy  (cfg_rdy),
    .cfg_key  (cfg_key),
    .cfg_nonce(cfg_nonce),
    .cfg_ctr  (cfg_ctr),
    .cfg_nblk (cfg_nblk),
    .abort    (abort),
    .out_if   (bus.master),
    .busy     (busy),
    .done     (done),
    .ctr_wrap (ctr_wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wd(input logic [511:0] v,
                                     input int i);
    return v[32*i+:32];
  endfunction

  function automatic logic [511:0] cha_exp(
      input logic [255:0] k, input logic [95:0] n,
      input logic [63:0] c);
    logic [31:0] w [16];
    logic [511:0] r;
    w[0] = C0; w[1] = C1; w[2] = C2; w[3] = C3;
    for (int i = 0; i < 8; i++) w[4+i] = k[32*i+:32];
    w[12] = c[31:0];
    for (int j = 0; j < 3; j++) w[13+j] = n[32*j+:32];
    for (int i = 0; i < 16; i++) r[32*i+:32] = w[i];
    return r;
  endfunction

  function automatic logic [511:0] sha_exp(
      input logic [255:0] k, input logic [95:0] n,
      input logic [63:0] c);
    logic [31:0] w [16];
    logic [511:0] r;
    w[0] = C0; w[5] = C1; w[10] = C2; w[15] = C3;
    for (int i = 0; i < 4; i++) begin
      w[1+i]  = k[32*i+:32];
      w[11+i] = k[32*(4+i)+:32];
    end
    w[6] = n[31:0];
    w[7] = n[63:32];
    w[8] = c[31:0];
    w[9] = c[63:32];
    for (int i = 0; i < 16; i++) r[32*i+:32] = w[i];
    return r;
  endfunction

  // Model: pending block counters waiting to be emitted.
  logic [63:0]  mq [$];
  logic [255:0] m_key = '0;
  logic [95:0]  m_nonce = '0;
  bit           m_done = 1'b0;
  bit           m_wrap = 1'b0;

  always @(posedge clk) begin
    logic [63:0] c;
    bit nd;
    nd = 1'b0;
    if (rst) begin
      mq.delete();
      m_wrap = 1'b0;
    end else if (mq.size() == 0) begin
      if (cfg_vld) begin
        m_key = cfg_key;
        m_nonce = cfg_nonce;
        m_wrap = 1'b0;
        if (cfg_nblk == 0) nd = 1'b1;
        for (int i = 0; i < int'(cfg_nblk); i++)
          mq.push_back(cfg_ctr + 64'(i));
      end
    end else begin
      if (out_rdy) begin
        c = mq.pop_front();
        if (c[31:0] == 32'hFFFF_FFFF && mq.size() > 0)
          m_wrap = 1'b1;
        if (mq.size() == 0 && !abort) nd = 1'b1;
      end
      if (abort) mq.delete();
    end
    m_done = nd;
  end

  always @(negedge clk) begin
    bit ev;
    ev = (mq.size() > 0);
    chk("cfg_rdy", 512'(cfg_rdy), 512'(!ev));
    chk("out_vld", 512'(bus.out_vld), 512'(ev));
    chk("busy", 512'(busy), 512'(ev));
    chk("done", 512'(done), 512'(m_done));
    chk("ctr_wrap", 512'(ctr_wrap), 512'(m_wrap));
    if (ev) begin
      chk("x_out_cha", bus.x_out_cha,
          cha_exp(m_key, m_nonce, mq[0]));
      chk("x_out_sha", bus.x_out_sha,
          sha_exp(m_key, m_nonce, mq[0]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] k,
                      input logic [95:0] n,
                      input logic [63:0] c,
                      input logic [15:0] nb);
    cfg_key = k;
    cfg_nonce = n;
    cfg_ctr = c;
    cfg_nblk = nb;
    cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (cfg_rdy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("wait_idle", 512'(cfg_rdy), 512'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] key;
    logic [95:0]  non;
    for (int b = 0; b < 32; b++) key[8*b+:8] = 8'(b);
    non = {32'h0, 32'h4a000000, 32'h09000000};

    rst = 1'b1;
    out_rdy = 1'b1;
    repeat (2) tick();
    chk("rst_cfg_rdy", 512'(cfg_rdy), 512'(1));
    chk("rst_out_vld", 512'(bus.out_vld), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_wrap", 512'(ctr_wrap), 512'(0));
    rst = 1'b0;
    tick();

    // RFC7539 block
    send(key, non, 64'd1, 16'd1);
    chk("t1_vld", 512'(bus.out_vld), 512'(1));
    chk("t1_w12", 512'(wd(bus.x_out_cha, 12)), 512'(1));
    chk("t1_w13", 512'(wd(bus.x_out_cha, 13)),
        512'(32'h09000000));
    chk("t1_w4", 512'(wd(bus.x_out_cha, 4)),
        512'(32'h03020100));
    chk("t1_w0", 512'(wd(bus.x_out_cha, 0)),
        512'(32'h61707865));
    tick();
    chk("t1_done", 512'(done), 512'(1));
    chk("t1_idle", 512'(bus.out_vld), 512'(0));
    tick();
    chk("t1_done_off", 512'(done), 512'(0));

    // three back-to-back beats
    send(key, non, 64'd1, 16'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_cha_w12", 512'(wd(bus.x_out_cha, 12)),
          512'(i + 1));
      chk("t2_sha_w8", 512'(wd(bus.x_out_sha, 8)),
          512'(i + 1));
      chk("t2_sha_w9", 512'(wd(bus.x_out_sha, 9)), 512'(0));
      tick();
    end
    chk("t2_done", 512'(done), 512'(1));
    chk("t2_rdy", 512'(cfg_rdy), 512'(1));

    // counter wrap, accepted in the done cycle
    send(key, non, 64'h00000000_FFFFFFFF, 16'd2);
    chk("t4_w12a", 512'(wd(bus.x_out_cha, 12)),
        512'(32'hFFFFFFFF));
    chk("t4_sha_a", 512'({wd(bus.x_out_sha, 9),
                          wd(bus.x_out_sha, 8)}),
        512'(64'h00000000_FFFFFFFF));
    tick();
    chk("t4_w12b", 512'(wd(bus.x_out_cha, 12)), 512'(0));
    chk("t4_sha_b", 512'({wd(bus.x_out_sha, 9),
                          wd(bus.x_out_sha, 8)}),
        512'(64'h00000001_00000000));
    chk("t4_wrap", 512'(ctr_wrap), 512'(1));
    tick();
    chk("t4_done", 512'(done), 512'(1));
    chk("t4_wrap_hold", 512'(ctr_wrap), 512'(1));
    tick();

    // backpressure
    send(key, non, 64'd10, 16'd4);
    chk("t3_wrap_clr", 512'(ctr_wrap), 512'(0));
    chk("t3_w12a", 512'(wd(bus.x_out_cha, 12)), 512'(10));
    tick();
    chk("t3_w12b", 512'(wd(bus.x_out_cha, 12)), 512'(11));
    out_rdy = 1'b0;
    repeat (5) begin
      tick();
      chk("t3_hold_vld", 512'(bus.out_vld), 512'(1));
      chk("t3_hold_w12", 512'(wd(bus.x_out_cha, 12)),
          512'(11));
      chk("t3_hold_w8", 512'(wd(bus.x_out_sha, 8)),
          512'(11));
    end
    out_rdy = 1'b1;
    tick();
    chk("t3_resume", 512'(wd(bus.x_out_cha, 12)), 512'(12));
    wait_idle();
    tick();

    // zero-length run
    send(key, non, 64'd5, 16'd0);
    chk("t5_done", 512'(done), 512'(1));
    chk("t5_vld", 512'(bus.out_vld), 512'(0));
    chk("t5_rdy", 512'(cfg_rdy), 512'(1));
    tick();
    chk("t5_done_off", 512'(done), 512'(0));
    chk("t5_vld_off", 512'(bus.out_vld), 512'(0));

    // reset during beat 2
    send(key, non, 64'd20, 16'd4);
    tick();
    chk("t6r_beat2", 512'(wd(bus.x_out_cha, 12)), 512'(21));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6r_vld", 512'(bus.out_vld), 512'(0));
    chk("t6r_done", 512'(done), 512'(0));
    chk("t6r_rdy", 512'(cfg_rdy), 512'(1));
    send(key, non, 64'd30, 16'd1);
    chk("t6r_new", 512'(wd(bus.x_out_cha, 12)), 512'(30));
    tick();
    chk("t6r_new_done", 512'(done), 512'(1));
    tick();

    // abort during beat 2
    send(key, non, 64'd40, 16'd4);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6a_vld", 512'(bus.out_vld), 512'(0));
    chk("t6a_done", 512'(done), 512'(0));
    chk("t6a_rdy", 512'(cfg_rdy), 512'(1));
    tick();
    chk("t6a_done2", 512'(done), 512'(0));

    // abort together with a cfg accept: cfg wins
    abort = 1'b1;
    send(key, non, 64'd50, 16'd1);
    abort = 1'b0;
    chk("t6a_cfg_vld", 512'(bus.out_vld), 512'(1));
    chk("t6a_cfg_w12", 512'(wd(bus.x_out_cha, 12)),
        512'(50));
    tick();
    chk("t6a_cfg_done", 512'(done), 512'(1));
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
